// File: rtl/power_iter_ctrl.sv
// Iteration controller: resets the vector register, then repeatedly launches the
// MVM and loads its result until convergence, the iteration limit, or a watchdog expiry.
module power_iter_ctrl #(
    parameter int ELEM_WIDTH = 4,
    parameter int ITER_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ITER_WIDTH-1:0]   max_iter,
    input  logic [4*ELEM_WIDTH-1:0] vec_cur,
    input  logic [4*ELEM_WIDTH-1:0] mvm_result,
    input  logic                    mvm_done,
    output logic                    mvm_start,
    output logic                    vec_reg_reset,
    output logic                    vec_load,
    output logic [ITER_WIDTH-1:0]   iter_count,
    output logic                    busy,
    output logic                    done,
    output logic                    converged,
    output logic                    timeout_err
);

    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, FINISH} state_t;

    state_t                state;
    state_t                next_state;
    logic [ITER_WIDTH-1:0] limit;
    logic [WD_WIDTH-1:0]   wd_cnt;
    logic                  result_match;
    logic                  wd_expire;
    logic                  last_round;

    assign result_match = (mvm_result == vec_cur);
    // Expires on the TIMEOUT-th WAIT cycle that passes without an answer.
    assign wd_expire    = (wd_cnt == WD_WIDTH'(TIMEOUT - 1));
    assign last_round   = ((iter_count + ITER_WIDTH'(1)) == limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = INIT;
            INIT:    next_state = (limit == '0) ? FINISH : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (mvm_done) begin
                    next_state = (result_match || last_round) ? FINISH : ISSUE;
                end else if (wd_expire) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mvm_start     = (state == ISSUE);
        vec_reg_reset = (state == INIT);
        done          = (state == FINISH);
        busy          = (state != IDLE);
        vec_load      = (state == WAIT) && mvm_done;
    end

    // Run bookkeeping; results stay visible in IDLE until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            limit       <= '0;
            iter_count  <= '0;
            converged   <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        limit       <= max_iter;
                        iter_count  <= '0;
                        converged   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (mvm_done) begin
                        iter_count <= iter_count + ITER_WIDTH'(1);
                        if (result_match) converged <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_WIDTH'(1);
                        if (wd_expire) timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
